// File: rtl/data_counter_bank.sv
// Bank of wrap-around up/down counters sharing one limit, stepped by
// edge-detected up/down requests on the selected channel.
// Optional auto-repeat on held inputs: define DATA_COUNTER_AUTO_REPEAT_EN.
module data_counter_bank #(
    parameter int unsigned  WIDTH       = 7,
    parameter int unsigned  CHANNELS    = 4,
    parameter int unsigned  REPEAT_DLY  = 50,
    parameter int unsigned  REPEAT_RATE = 10,
    localparam int unsigned SEL_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      w_r,
    input  logic                      en,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      up,
    input  logic                      down,
    input  logic [WIDTH-1:0]          limit,
    output logic [WIDTH-1:0]          count,
    output logic [CHANNELS*WIDTH-1:0] all_counts,
    output logic                      wrap
);

    logic                           up_q, down_q;
    logic [CHANNELS-1:0][WIDTH-1:0] cnt_q, cnt_d;
    logic                           wrap_q, wrap_d;
    logic                           sel_ok, up_edge, dn_edge;
    logic                           do_up, do_dn;
    logic                           rep_up_due, rep_dn_due;
    logic [WIDTH-1:0]               cur;

    assign sel_ok     = (32'(sel) < CHANNELS);
    assign up_edge    = up & ~up_q;
    assign dn_edge    = down & ~down_q;
    assign cur        = cnt_q[sel];
    assign count      = sel_ok ? cnt_q[sel] : '0;
    assign all_counts = cnt_q;
    assign wrap       = wrap_q;

    // Step arbitration: up (edge or repeat) wins over down; a losing down edge is dropped
    always_comb begin
        do_up = 1'b0;
        do_dn = 1'b0;
        if (!w_r && en && sel_ok) begin
            do_up = up_edge | rep_up_due;
            do_dn = ~do_up & (dn_edge | rep_dn_due);
        end
    end

    // Next channel values and wrap flag
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        if (w_r) begin
            cnt_d = '0;
        end else if (do_up) begin
            if (cur >= limit) begin
                cnt_d[sel] = '0;
                wrap_d     = 1'b1;
            end else begin
                cnt_d[sel] = cur + WIDTH'(1);
            end
        end else if (do_dn) begin
            if (cur == '0) begin
                cnt_d[sel] = limit;
                wrap_d     = 1'b1;
            end else begin
                cnt_d[sel] = cur - WIDTH'(1);
            end
        end
    end

    // Input history and channel registers; history presets high so a held input is not an edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            up_q   <= 1'b1;
            down_q <= 1'b1;
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            up_q   <= up;
            down_q <= down;
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

`ifdef DATA_COUNTER_AUTO_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

    logic             rep_act_q, rep_act_d;
    logic             rep_up_q, rep_up_d;
    logic             rep_rate_q, rep_rate_d;
    logic [SEL_W-1:0] rep_sel_q, rep_sel_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [REP_W-1:0] rep_inc, rep_tgt;
    logic             rep_keep, rep_hit;

    assign rep_keep   = rep_act_q & (rep_up_q ? up : down) & (sel == rep_sel_q) & ~w_r;
    assign rep_inc    = rep_cnt_q + REP_W'(1);
    assign rep_tgt    = rep_rate_q ? REP_W'(REPEAT_RATE) : REP_W'(REPEAT_DLY);
    assign rep_hit    = rep_keep & en & (rep_inc == rep_tgt);
    assign rep_up_due = rep_hit & rep_up_q;
    assign rep_dn_due = rep_hit & ~rep_up_q;

    // Repeat timer: armed by an edge step, counts en cycles while the key stays held
    always_comb begin
        rep_act_d  = rep_act_q;
        rep_up_d   = rep_up_q;
        rep_rate_d = rep_rate_q;
        rep_sel_d  = rep_sel_q;
        rep_cnt_d  = rep_cnt_q;
        if (!rep_keep) begin
            rep_act_d  = 1'b0;
            rep_rate_d = 1'b0;
            rep_cnt_d  = '0;
        end else if (en) begin
            if (rep_inc == rep_tgt) begin
                rep_cnt_d  = '0;
                rep_rate_d = 1'b1;
            end else begin
                rep_cnt_d = rep_inc;
            end
        end
        if ((do_up && up_edge) || (do_dn && dn_edge)) begin
            rep_act_d  = 1'b1;
            rep_up_d   = do_up;
            rep_sel_d  = sel;
            rep_cnt_d  = '0;
            rep_rate_d = 1'b0;
        end
    end

    // Repeat state registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            rep_act_q  <= 1'b0;
            rep_up_q   <= 1'b0;
            rep_rate_q <= 1'b0;
            rep_sel_q  <= '0;
            rep_cnt_q  <= '0;
        end else begin
            rep_act_q  <= rep_act_d;
            rep_up_q   <= rep_up_d;
            rep_rate_q <= rep_rate_d;
            rep_sel_q  <= rep_sel_d;
            rep_cnt_q  <= rep_cnt_d;
        end
    end
`else
    logic rep_cfg_unused;

    assign rep_up_due     = 1'b0;
    assign rep_dn_due     = 1'b0;
    assign rep_cfg_unused = (REPEAT_DLY == 0) | (REPEAT_RATE == 0);
`endif

endmodule
